// File: rtl/param_seq_detector.sv
// Runtime-programmable serial pattern detector with overlap control and a saturating match counter.
// The pattern is received MSB-first: bit [len-1] first, bit [0] last.
module param_seq_detector #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  input  logic             in_valid,
  input  logic             data_in,
  output logic             detected,
  output logic [CNT_W-1:0] match_count,
  output logic             armed,
  output logic             cfg_err
);

  typedef enum logic {UNCFG = 1'b0, HUNT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] hist_q, hist_d, pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d, fill_q, fill_d;
  logic             ovl_q, ovl_d, det_q, det_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;

  logic [PAT_W-1:0] hist_shift, len_mask;
  logic [LEN_W:0]   fill_inc;
  logic             len_ok, match;

  always_comb begin
    for (int i = 0; i < PAT_W; i++) len_mask[i] = (i < int'(len_q));
  end

  assign hist_shift = {hist_q[PAT_W-2:0], data_in};
  // One bit wider so fill+1 cannot wrap when fill already equals len.
  assign fill_inc   = {1'b0, fill_q} + (LEN_W+1)'(1);
  assign len_ok     = (cfg_len != '0) && ({1'b0, cfg_len} <= (LEN_W+1)'(PAT_W));
  assign match      = (state_q == HUNT) && in_valid && !cfg_load &&
                      (fill_inc >= {1'b0, len_q}) &&
                      (((hist_shift ^ pat_q) & len_mask) == '0);

  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    pat_d    = pat_q;
    len_d    = len_q;
    fill_d   = fill_q;
    ovl_d    = ovl_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    det_d    = 1'b0;
    cnt_base = cnt_q;
    if (cfg_load) begin
      pat_d   = cfg_pattern;
      len_d   = cfg_len;
      ovl_d   = cfg_overlap;
      hist_d  = '0;
      fill_d  = '0;
      cnt_d   = '0;
      state_d = len_ok ? HUNT : UNCFG;
      err_d   = !len_ok;
    end else begin
      if (state_q == HUNT && in_valid) begin
        hist_d = hist_shift;
        det_d  = match;
        if (match && !ovl_q)                fill_d = '0;
        else if (fill_inc >= {1'b0, len_q}) fill_d = len_q;
        else                                fill_d = fill_inc[LEN_W-1:0];
      end
      cnt_base = cnt_clr ? '0 : cnt_q;
      cnt_d    = (match && cnt_base != '1) ? cnt_base + CNT_W'(1) : cnt_base;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNCFG;
      hist_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      ovl_q   <= 1'b0;
      det_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      ovl_q   <= ovl_d;
      det_q   <= det_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign detected    = det_q;
  assign match_count = cnt_q;
  assign armed       = (state_q == HUNT);
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_param_seq_detector.sv
// Directed-vector bench for param_seq_detector; a second instance with CNT_W=2 covers saturation.
module tb_param_seq_detector;
  localparam int PAT_W = 8;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst, cfg_load, cfg_overlap, cnt_clr, in_valid, data_in;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             det, armed, err, det2, armed2, err2;
  logic [15:0]      cnt;
  logic [1:0]       cnt2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  param_seq_detector #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .data_in(data_in), .detected(det),
    .match_count(cnt), .armed(armed), .cfg_err(err));

  param_seq_detector #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .data_in(data_in), .detected(det2),
    .match_count(cnt2), .armed(armed2), .cfg_err(err2));

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Each task drives after the previous edge and returns 1ns after its own edge.
  task automatic tick();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic load(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len, input logic ovl);
    cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    tick();
  endtask

  task automatic send(input logic b);
    in_valid = 1'b1; data_in = b;
    tick();
  endtask

  // Streams bits (first bit at index n-1) and checks detected after each one.
  task automatic stream(input string tag, input logic [7:0] bits, input logic [7:0] dexp, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i]);
      check($sformatf("%s_det%0d", tag, n - i), int'(det), int'(dexp[i]));
    end
  endtask

  initial begin
    rst = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cnt_clr = 1'b0; in_valid = 1'b0; data_in = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    tick();
    check("rst_det", int'(det), 0);
    check("rst_cnt", int'(cnt), 0);
    check("rst_armed", int'(armed), 0);
    check("rst_err", int'(err), 0);

    // Overlapping 101
    load(8'b101, 4'd3, 1'b1);
    check("ov_armed", int'(armed), 1);
    stream("ov", 8'b10101, 8'b00101, 5);
    check("ov_cnt", int'(cnt), 2);

    // Non-overlapping 101, then a second burst
    load(8'b101, 4'd3, 1'b0);
    check("nov_cnt0", int'(cnt), 0);
    stream("nov", 8'b10101, 8'b00100, 5);
    check("nov_cnt", int'(cnt), 1);
    stream("nov2", 8'b101, 8'b001, 3);
    check("nov2_cnt", int'(cnt), 2);

    // 0xA5 with a 3-cycle in_valid gap after the 4th bit
    load(8'hA5, 4'd8, 1'b0);
    stream("a5a", 8'b1010, 8'b0000, 4);
    for (int g = 0; g < 3; g++) begin
      tick();
      check("a5_gap_det", int'(det), 0);
    end
    stream("a5b", 8'b0101, 8'b0001, 4);
    check("a5_cnt", int'(cnt), 1);
    tick();
    check("a5_pulse_one_cycle", int'(det), 0);

    // cfg_load beats in_valid: the bit in the load cycle is dropped
    cfg_load = 1'b1; cfg_pattern = 8'b1; cfg_len = 4'd1; cfg_overlap = 1'b0;
    in_valid = 1'b1; data_in = 1'b1;
    tick();
    check("ld_prio_det", int'(det), 0);
    check("ld_prio_cnt", int'(cnt), 0);

    // Illegal lengths
    load(8'hFF, 4'd9, 1'b1);
    check("len9_err", int'(err), 1);
    check("len9_armed", int'(armed), 0);
    load(8'hFF, 4'd0, 1'b1);
    check("len0_err", int'(err), 1);
    check("len0_armed", int'(armed), 0);
    stream("len0", 8'b111, 8'b000, 3);
    check("len0_cnt", int'(cnt), 0);
    load(8'b11, 4'd2, 1'b1);
    check("len2_err", int'(err), 0);
    stream("len2", 8'b1111, 8'b0111, 4);
    check("len2_cnt", int'(cnt), 3);

    // len=1 with a 2-bit counter: saturation and clear-with-match
    load(8'b1, 4'd1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      send(1'b1);
      check("sat_det", int'(det2), 1);
      check("sat_cnt", int'(cnt2), (k < 3) ? k : 3);
    end
    check("sat_wide_cnt", int'(cnt), 5);
    cnt_clr = 1'b1;
    send(1'b1);
    check("clr_match_cnt2", int'(cnt2), 1);
    check("clr_match_cnt", int'(cnt), 1);
    send(1'b0);
    check("len1_zero_det", int'(det), 0);
    cnt_clr = 1'b1;
    tick();
    check("clr_alone_cnt", int'(cnt), 0);

    // Reset in the middle of a partial match
    load(8'b101, 4'd3, 1'b1);
    send(1'b1);
    send(1'b0);
    rst = 1'b1;
    tick();
    send(1'b1);
    check("mid_rst_det", int'(det), 0);
    check("mid_rst_armed", int'(armed), 0);
    check("mid_rst_cnt", int'(cnt), 0);
    check("mid_rst_err", int'(err), 0);
    stream("post_rst", 8'b101, 8'b000, 3);
    load(8'b101, 4'd3, 1'b1);
    stream("reload", 8'b101, 8'b001, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_seq_detector.md
Name: param_seq_detector

Overview:
- Runtime-programmable serial pattern detector and the parametrised successor to the fixed "101" detector.
- Pattern bits, pattern length (1..PAT_W) and overlap mode are loaded at runtime.
- Input bits are qualified by in_valid; each match produces a one-cycle detect pulse and increments a saturating match counter.
- Sits in front of framing/sync logic that searches serial streams for sync words.

Parameters:
- PAT_W, default 8: maximum pattern length in bits (>=2).
- LEN_W, default 4: width of cfg_len; must hold PAT_W (>= clog2(PAT_W+1)).
- CNT_W, default 16: width of match_count.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_load  in  1  single-cycle strobe that latches cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  PAT_W  pattern bits; bit [cfg_len-1] is received first, bit [0] last; bits at or above cfg_len are ignored.
- cfg_len  in  LEN_W  pattern length; legal range 1..PAT_W.
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_count.
- in_valid  in  1  data_in is sampled on a rising edge only when in_valid=1.
- data_in  in  1  serial input bit.
- detected  out  1  one-cycle pulse per match.
- match_count  out  CNT_W  saturating count of matches.
- armed  out  1  high when a legal configuration is loaded (state HUNT).
- cfg_err  out  1  high while the last cfg_load carried an illegal cfg_len.

Behaviour:
- Reset (rst=1 at an edge) sets: state=UNCFG, hist=0, fill=0, detected=0, match_count=0, armed=0, cfg_err=0, and clears the stored pattern, length and overlap registers. Reset overrides every other input, including mid-pattern.
- FSM states:
  - UNCFG: no detection. in_valid bits are discarded.
  - HUNT: bits are shifted in and matched. armed = (state==HUNT).
- cfg_load=1, any state:
  - Latch the configuration and clear hist, fill and match_count. detected=0 that cycle.
  - If 1<=cfg_len<=PAT_W: go to HUNT, cfg_err=0.
  - Otherwise: go to UNCFG, cfg_err=1.
- cfg_load has priority over in_valid in the same cycle; that data bit is dropped.
- In HUNT, for each edge with in_valid=1:
  - hist <= {hist[PAT_W-2:0], data_in}.
  - fill <= min(fill+1, len).
  - Match condition: (fill+1 >= len) and the new hist[len-1:0] equals pattern[len-1:0].
- On a match:
  - detected=1 for exactly one cycle, registered: visible immediately after the edge that sampled the final pattern bit.
  - match_count increments.
  - If overlap=0, fill <= 0, so the next match needs len fresh bits. If overlap=1, fill is unchanged.
- Edges with in_valid=0: hist and fill hold, detected=0. Gaps in in_valid do not break a partial match.
- match_count:
  - Saturates at 2^CNT_W-1, with no wrap. detected still pulses at saturation.
  - cnt_clr alone sets it to 0.
  - cnt_clr together with a match sets it to 1.
  - cfg_load clears it regardless.
- len=1: every valid bit equal to pattern[0] is a match; the overlap setting has no effect.

Test Plan:
- Reset, then load pattern=3'b101, len=3, overlap=1; stream 1,0,1,0,1 with in_valid=1 -> detected pulses after bits 3 and 5; match_count=2; armed=1.
- Same stream with overlap=0 -> one pulse after bit 3, none after bit 5, match_count=1. Then stream 1,0,1 -> pulse after bit 3 of this burst (6th bit overall), match_count=2.
- Load pattern=8'hA5, len=8, overlap=0; send 0xA5 MSB-first with in_valid dropped for 3 cycles between bits 4 and 5 -> exactly one pulse after the 8th valid bit; no pulses during the gap.
- Load cfg_len=0 -> armed=0, cfg_err=1; stream 1,1,1 -> no pulses, match_count=0. Then load len=2, pattern=2'b11, overlap=1 and stream 1,1,1,1 -> 3 pulses, cfg_err=0.
- Build with CNT_W=2 and pattern 1'b1, len=1; send 5 ones -> match_count goes 1,2,3,3,3; detected pulses 5 times. Assert cnt_clr together with a 6th one -> match_count=1.
- After 2 of the 3 bits of 101 have been received, assert rst for 1 cycle, then send 1 -> no pulse; state=UNCFG, armed=0, match_count=0. The pattern must be reloaded to resume detection.
